// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

  // Bits needed to hold any value 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-bit, pattern-control and status bundle between the front-end and the detector.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_bit;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in_bit, overlap_en, pat_load, pat_in, count_clr,
    input  out, match_count
  );

  modport slave (
    input  in_valid, in_bit, overlap_en, pat_load, pat_in, count_clr,
    output out, match_count
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with runtime pattern reload, overlap select and
// a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1101),
  parameter int               CNT_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  seq_detector_param_if.slave bus
);

  localparam int                FILL_W    = clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_pat_w_check
    $error("seq_detector_param: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
  end

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic              out_q;
  logic [CNT_W-1:0]  cnt;

  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              match;

  // A match needs a full window of fresh bits; pat_load suppresses the bit on its edge.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], bus.in_bit};
    fill_n = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match  = bus.in_valid && !bus.pat_load &&
             (fill_n == FILL_FULL) && (hist_n == pattern);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= DEFAULT_PAT;
      hist    <= '0;
      fill    <= '0;
      out_q   <= 1'b0;
    end else if (bus.pat_load) begin
      pattern <= bus.pat_in;
      hist    <= '0;
      fill    <= '0;
      out_q   <= 1'b0;
    end else if (bus.in_valid) begin
      hist  <= hist_n;
      out_q <= match;
      // Non-overlap restarts the window so the next match needs PAT_W new bits.
      fill  <= (match && !bus.overlap_en) ? '0 : fill_n;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match),
    .clr  (bus.count_clr),
    .cnt  (cnt)
  );

  assign bus.out         = out_q;
  assign bus.match_count = cnt;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore-style serial pattern detector. It is the generalised successor of the team's fixed 4-bit overlapping detectors.
- Pattern length is set by a parameter. The pattern value can be reloaded at runtime.
- Overlap versus non-overlap is selected at runtime. Input is qualified by a valid strobe, so stalls are allowed.
- A saturating match counter is included. Sits between serial front-end logic and status/interrupt registers.

Parameters:
- PAT_W, 4, pattern length in bits. Legal range 2..32; elaboration error outside this range.
- DEFAULT_PAT, 4'b1101 (PAT_W bits), pattern value loaded at reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is consumed on this rising edge.
- in_bit  input  1  serial data; the first-received bit is compared against pattern MSB.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on each valid bit.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PAT_W  new pattern value.
- count_clr  input  1  synchronous clear of match_count.
- out  output  1  Moore match flag, registered.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pattern=DEFAULT_PAT, hist=0, fill=0, out=0, match_count=0.
  - Release is synchronous to clk, with no special handling needed.
- State held in registers:
  - pattern[PAT_W-1:0].
  - hist[PAT_W-1:0]: last received bits, newest in the LSB.
  - fill: 0..PAT_W, saturating count of valid bits since the last restart.
  - out.
  - match_count.
- Valid bit (in_valid=1, pat_load=0):
  - hist_n = {hist[PAT_W-2:0], in_bit}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==pattern).
  - On the edge: out<=match; hist<=hist_n.
  - fill<=0 if match && !overlap_en, else fill_n.
- Latency:
  - out rises in the cycle after the edge that sampled the final pattern bit, i.e. one cycle after the last bit.
  - This is Moore behaviour: out is purely a register, with no combinational path from inputs.
- Stall (in_valid=0): all state is held, including out. A match flag stays high until the next valid bit or pat_load.
- Back-to-back matches (overlap mode, e.g. pattern 1111 with stream 11111): out stays high for consecutive valid bits. match_count increments once per matching valid bit.
- Non-overlap: after a match, a new match needs PAT_W fresh bits.
- pat_load=1:
  - pattern<=pat_in; fill<=0; out<=0; hist<=0.
  - in_valid on the same edge is ignored, so that bit is dropped.
  - match_count is unaffected.
- match_count:
  - Increments on each edge where match=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - count_clr wins over a simultaneous increment: the result is 0 and that match is not counted. out is still set.
- Reset mid-sequence: partial history is discarded. Detection restarts with fill=0.
- Unknown/illegal fill values cannot occur. fill saturates, and the compare uses fill==PAT_W only.

Decomposition:
- Package seq_det_pkg holds:
  - PAT_W_MIN=2 and PAT_W_MAX=32 for the elaboration check.
  - The function clog2 for the fill width ($clog2(PAT_W+1)).
- One sub-module: sat_counter, parametrised by width, with inputs inc and clr (clr has priority) and output cnt. It is instantiated for match_count.
- The shift/compare and fill logic stays in seq_detector_param.

Test Plan:
- Reset then stream 1,1,0,1,1,0,1 (one per cycle, overlap_en=1, default pattern 1101) -> out high in the cycle after bits 4 and 7; match_count=2.
- Same stream with overlap_en=0 -> out high only after bit 4; match_count=1.
- pat_load with pat_in=0110, then stream 0,1,1,0,1,1,0 in overlap mode -> out high after bits 4 and 7.
- Bit driven with in_valid=1 on the pat_load edge -> that bit is dropped.
- Default pattern, stream 1,1, then in_valid=0 for 3 cycles, then 0,1 -> out high after the final bit. out holds high through a further 2-cycle stall. The next valid 0 -> out=0.
- Stream 1,1,0, assert rst_n=0 for 1 cycle, then bit 1 -> no match; out=0, match_count=0.
- CNT_W=2, overlap mode, pattern 1111, stream of 7 ones -> match_count counts 1,2,3,3 (saturates).
- count_clr on the edge of the next match -> match_count=0, out=1.
